vga_pattern_sequencer: RTL and testbench
========================================

Name: vga_pattern_sequencer

Overview:
- Frame-synchronous controller that chooses which palette colour index drives the VGA test-pattern datapath.
- Either auto-cycles indices 1..7 every FRAMES_PER_STEP frames, or advances one step per button press.
- Changes apply only at the vsync assertion edge, so a frame never tears mid-scan.
- Sits between the hvsync generator and the palette lookup, taking ui_in controls.

Parameters:
FRAMES_PER_STEP, 60, frames each index is held in auto mode (legal 1..255).
VSYNC_ACTIVE_LOW, 1, 1 = vsync asserted when 0; 0 = asserted when 1.

Ports:
clk  in  1  pixel clock.
reset  in  1  synchronous, active-high reset.
vsync  in  1  vsync from the hvsync generator, synchronous to clk.
auto_en  in  1  asynchronous level from ui_in; 1 = auto-cycle.
step_btn  in  1  asynchronous push button from ui_in; each rising edge requests one step.
color_index  out  3  current palette index, always in 1..7.
advance  out  1  one-cycle pulse, high in the cycle color_index takes its new value.
auto_active  out  1  1 when the FSM is in AUTO.
frame_cnt  out  8  free-running frame counter, wraps 255->0.

Behaviour:
- Reset values: color_index=1, advance=0, auto_active=0, frame_cnt=0, dwell=0, pending=0, state=MANUAL. All synchronizer flops reset to 0. vsync_d resets to the asserted level, so reset release during vsync gives no spurious edge.
- Frame edge: frame_edge = vsync asserted now AND vsync_d deasserted (vsync_d is the registered vsync). It is a combinational pulse at most one cycle long.
- On frame_edge: frame_cnt increments, and any index update is registered on the same clk edge. The new index is visible the cycle after vsync asserts.
- Synchronizers: auto_en and step_btn each pass through a 2-FF synchronizer plus an edge register. The step rising edge reaches pending 3 cycles after the pin rises. Mode decisions use the synchronized auto_en.
- Index step: 1->2->...->7->1. Value 0 is never produced.
- FSM MANUAL:
  - A step edge sets pending; repeated edges while pending stays set are absorbed, giving one step.
  - On frame_edge with pending=1: advance index, pulse advance, clear pending.
  - Synchronized auto_en=1: go to AUTO, clear dwell, keep pending.
- FSM AUTO:
  - On frame_edge: if dwell==FRAMES_PER_STEP-1 or pending=1, advance index, dwell=0, pending=0. Otherwise dwell+1.
  - A step edge sets pending, forcing an early advance at the next frame edge; dwell restarts from 0.
  - Dwell expiry coinciding with pending gives a single advance, not two.
  - Synchronized auto_en=0: go to MANUAL, clear dwell; index holds.
- Simultaneous cases:
  - Step edge in the same cycle as frame_edge: pending is set and takes effect at the following frame edge.
  - Mode change in the same cycle as frame_edge: evaluate using the current state, then transition.
- FRAMES_PER_STEP=1: advances every frame in AUTO.
- dwell is 8 bits and never exceeds FRAMES_PER_STEP-1.
- Reset asserted mid-operation restores all reset values on the next clk edge; pending steps are discarded.

Decomposition:
- Shared package vga_pkg:
  - state typedef {MANUAL, AUTO};
  - constants IDX_FIRST=3'd1, IDX_LAST=3'd7;
  - localparam DWELL_W=8.
- One sub-module, sync_edge_detect: 2-FF synchronizer with registered rising-edge pulse output and level output. Instantiate it twice (step_btn, auto_en).

Test Plan:
- Reset held 4 cycles, vsync toggling -> color_index=1, advance=0, frame_cnt=0, auto_active=0 throughout.
- MANUAL, one step_btn press 10 cycles wide, then 3 frames -> exactly one advance pulse, at the first frame edge after press+3 cycles; color_index 1->2 and stays 2.
- FRAMES_PER_STEP=3, auto_en=1, 22 frames:
  - color_index steps every 3rd frame edge: 1,2,..,7,1;
  - wrap 7->1 occurs on frame 21;
  - frame_cnt=22.
- AUTO with dwell=1, press step -> advance at next frame edge, dwell resets; next auto advance 3 frames later, not 1.
- Press step in the exact cycle of frame_edge and also on dwell expiry -> single advance per frame edge, never +2.
- Reset asserted mid-frame with pending=1 and color_index=5 -> next cycle color_index=1, pending cleared, no advance at the following frame edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern sequencer.
package vga_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } seq_state_e;

  localparam logic [2:0] IDX_FIRST = 3'd1;
  localparam logic [2:0] IDX_LAST  = 3'd7;
  localparam int         DWELL_W   = 8;

  // Next palette index in the 1..7 ring; an out-of-range value recovers to the first index.
  function automatic logic [2:0] next_index(input logic [2:0] idx);
    logic [2:0] nxt;
    if ((idx >= IDX_LAST) || (idx < IDX_FIRST)) begin
      nxt = IDX_FIRST;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin with a registered rising-edge pulse.
// The edge flop samples the first stage against the second, so it acts as a
// second-stage flop itself and the pulse lines up with the synchronized level.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic rise_r;

  // Synchronize the pin and register a one-cycle pulse on its rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      rise_r  <= sync1_r & ~sync2_r;
    end
  end

  assign level = sync2_r;
  assign rise  = rise_r;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous palette index sequencer: auto-cycles or steps on button
// presses, and only ever changes the index on the vsync assertion edge.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int FRAMES_PER_STEP  = 60,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       auto_en,
  input  logic       step_btn,
  output logic [2:0] color_index,
  output logic       advance,
  output logic       auto_active,
  output logic [7:0] frame_cnt
);

  localparam logic VSYNC_ASSERTED = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(FRAMES_PER_STEP - 1);

  seq_state_e          state_r;
  logic [2:0]          color_index_r;
  logic                advance_r;
  logic                auto_active_r;
  logic [7:0]          frame_cnt_r;
  logic [DWELL_W-1:0]  dwell_r;
  logic                pending_r;
  logic                vsync_d_r;

  logic                frame_edge_s;
  logic                step_rise_s;
  logic                step_level_s;
  logic                auto_level_s;
  logic                auto_rise_s;
  logic                unused_sync_s;

  sync_edge_detect u_step_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (step_btn),
    .level    (step_level_s),
    .rise     (step_rise_s)
  );

  sync_edge_detect u_auto_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (auto_en),
    .level    (auto_level_s),
    .rise     (auto_rise_s)
  );

  // The button only matters as an edge and the mode switch only as a level.
  assign unused_sync_s = step_level_s ^ auto_rise_s;

  // Frame edge: vsync asserted now but not in the previous cycle.
  always_comb begin
    frame_edge_s = 1'b0;
    if ((vsync == VSYNC_ASSERTED) && (vsync_d_r != VSYNC_ASSERTED)) begin
      frame_edge_s = 1'b1;
    end else begin
      frame_edge_s = 1'b0;
    end
  end

  // Mode FSM, dwell timer, step request and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= MANUAL;
      color_index_r <= IDX_FIRST;
      advance_r     <= 1'b0;
      auto_active_r <= 1'b0;
      frame_cnt_r   <= 8'd0;
      dwell_r       <= '0;
      pending_r     <= 1'b0;
      vsync_d_r     <= VSYNC_ASSERTED;
    end else begin
      vsync_d_r <= vsync;
      advance_r <= 1'b0;
      if (frame_edge_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
      case (state_r)
        MANUAL: begin
          if (frame_edge_s && pending_r) begin
            color_index_r <= next_index(color_index_r);
            advance_r     <= 1'b1;
            pending_r     <= 1'b0;
          end
          // A press landing on the frame edge is kept for the next frame.
          if (step_rise_s) begin
            pending_r <= 1'b1;
          end
          if (auto_level_s) begin
            state_r       <= AUTO;
            auto_active_r <= 1'b1;
            dwell_r       <= '0;
          end
        end
        AUTO: begin
          if (frame_edge_s) begin
            // Dwell expiry and a pending press together still yield one step.
            if ((dwell_r >= DWELL_MAX) || pending_r) begin
              color_index_r <= next_index(color_index_r);
              advance_r     <= 1'b1;
              dwell_r       <= '0;
              pending_r     <= 1'b0;
            end else begin
              dwell_r <= dwell_r + 8'd1;
            end
          end
          if (step_rise_s) begin
            pending_r <= 1'b1;
          end
          if (!auto_level_s) begin
            state_r       <= MANUAL;
            auto_active_r <= 1'b0;
            dwell_r       <= '0;
          end
        end
        default: begin
          state_r       <= MANUAL;
          auto_active_r <= 1'b0;
          dwell_r       <= '0;
          pending_r     <= 1'b0;
        end
      endcase
    end
  end

  assign color_index = color_index_r;
  assign advance     = advance_r;
  assign auto_active = auto_active_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed, table-driven bench for vga_pattern_sequencer with FRAMES_PER_STEP=3.
module tb_vga_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       auto_en;
  logic       step_btn;
  logic [2:0] color_index;
  logic       advance;
  logic       auto_active;
  logic [7:0] frame_cnt;

  int         n_vec = 0;
  int         n_err = 0;
  int         adv_seen = 0;
  logic [7:0] exp_fc;

  typedef struct {
    int         presses;     // full presses well before the frame edge
    bit         press_same;  // press whose edge lands on the frame edge
    bit         auto_v;      // auto_en level for this frame
    logic [2:0] exp_idx;     // color_index right after the frame edge
    bit         exp_adv;     // advance pulses expected in this frame
  } vec_t;

  vec_t vecs[45];

  vga_pattern_sequencer #(
    .FRAMES_PER_STEP  (3),
    .VSYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .auto_en     (auto_en),
    .step_btn    (step_btn),
    .color_index (color_index),
    .advance     (advance),
    .auto_active (auto_active),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // Count every advance pulse so extra or missing pulses are caught.
  always @(negedge clk) begin
    if (advance === 1'b1) adv_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_v(input int i, input int pr, input bit same, input bit au,
                       input logic [2:0] idx, input bit adv);
    vecs[i].presses    = pr;
    vecs[i].press_same = same;
    vecs[i].auto_v     = au;
    vecs[i].exp_idx    = idx;
    vecs[i].exp_adv    = adv;
  endtask

  task automatic press_btn();
    step_btn = 1'b1;
    repeat (10) @(negedge clk);
    step_btn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // One frame: settle the mode, apply presses, assert vsync, check after the edge.
  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    auto_en  = v.auto_v;
    adv_seen = 0;
    repeat (6) @(negedge clk);
    for (int p = 0; p < v.presses; p++) press_btn();
    if (v.press_same) begin
      step_btn = 1'b1;
      repeat (2) @(negedge clk);
    end
    vsync  = 1'b0;
    exp_fc = exp_fc + 8'd1;
    @(posedge clk);
    #1;
    check($sformatf("v%0d_idx", i), int'(color_index), int'(v.exp_idx));
    check($sformatf("v%0d_adv", i), int'(advance), int'(v.exp_adv));
    check($sformatf("v%0d_fcnt", i), int'(frame_cnt), int'(exp_fc));
    check($sformatf("v%0d_auto", i), int'(auto_active), int'(v.auto_v));
    repeat (3) @(negedge clk);
    vsync    = 1'b1;
    step_btn = 1'b0;
    repeat (4) @(negedge clk);
    check($sformatf("v%0d_advcount", i), adv_seen, int'(v.exp_adv));
  endtask

  initial begin
    // Manual mode: press, absorbed repeats, press on the frame edge, mode round trip.
    set_v(0, 1, 1'b0, 1'b0, 3'd2, 1'b1);
    set_v(1, 0, 1'b0, 1'b0, 3'd2, 1'b0);
    set_v(2, 0, 1'b0, 1'b0, 3'd2, 1'b0);
    set_v(3, 0, 1'b1, 1'b0, 3'd2, 1'b0);
    set_v(4, 0, 1'b0, 1'b0, 3'd3, 1'b1);
    set_v(5, 2, 1'b0, 1'b0, 3'd4, 1'b1);
    set_v(6, 0, 1'b0, 1'b0, 3'd4, 1'b0);
    set_v(7, 0, 1'b0, 1'b1, 3'd4, 1'b0);
    set_v(8, 0, 1'b0, 1'b1, 3'd4, 1'b0);
    set_v(9, 0, 1'b0, 1'b1, 3'd5, 1'b1);
    set_v(10, 0, 1'b0, 1'b0, 3'd5, 1'b0);
    // First frame after a reset that discarded a pending press.
    set_v(11, 0, 1'b0, 1'b0, 3'd1, 1'b0);
    // Auto mode from reset: 22 frames, steps on every third edge, wrap at frame 21.
    set_v(12, 0, 1'b0, 1'b1, 3'd1, 1'b0);
    set_v(13, 0, 1'b0, 1'b1, 3'd1, 1'b0);
    set_v(14, 0, 1'b0, 1'b1, 3'd2, 1'b1);
    set_v(15, 0, 1'b0, 1'b1, 3'd2, 1'b0);
    set_v(16, 0, 1'b0, 1'b1, 3'd2, 1'b0);
    set_v(17, 0, 1'b0, 1'b1, 3'd3, 1'b1);
    set_v(18, 0, 1'b0, 1'b1, 3'd3, 1'b0);
    set_v(19, 0, 1'b0, 1'b1, 3'd3, 1'b0);
    set_v(20, 0, 1'b0, 1'b1, 3'd4, 1'b1);
    set_v(21, 0, 1'b0, 1'b1, 3'd4, 1'b0);
    set_v(22, 0, 1'b0, 1'b1, 3'd4, 1'b0);
    set_v(23, 0, 1'b0, 1'b1, 3'd5, 1'b1);
    set_v(24, 0, 1'b0, 1'b1, 3'd5, 1'b0);
    set_v(25, 0, 1'b0, 1'b1, 3'd5, 1'b0);
    set_v(26, 0, 1'b0, 1'b1, 3'd6, 1'b1);
    set_v(27, 0, 1'b0, 1'b1, 3'd6, 1'b0);
    set_v(28, 0, 1'b0, 1'b1, 3'd6, 1'b0);
    set_v(29, 0, 1'b0, 1'b1, 3'd7, 1'b1);
    set_v(30, 0, 1'b0, 1'b1, 3'd7, 1'b0);
    set_v(31, 0, 1'b0, 1'b1, 3'd7, 1'b0);
    set_v(32, 0, 1'b0, 1'b1, 3'd1, 1'b1);
    set_v(33, 0, 1'b0, 1'b1, 3'd1, 1'b0);
    // Dwell is 1: early press advances now, the next auto step is 3 frames on.
    set_v(34, 1, 1'b0, 1'b1, 3'd2, 1'b1);
    set_v(35, 0, 1'b0, 1'b1, 3'd2, 1'b0);
    set_v(36, 0, 1'b0, 1'b1, 3'd2, 1'b0);
    set_v(37, 0, 1'b0, 1'b1, 3'd3, 1'b1);
    set_v(38, 0, 1'b0, 1'b1, 3'd3, 1'b0);
    set_v(39, 0, 1'b0, 1'b1, 3'd3, 1'b0);
    // Press edge on the dwell-expiry frame edge: one step now, one next frame.
    set_v(40, 0, 1'b1, 1'b1, 3'd4, 1'b1);
    set_v(41, 0, 1'b0, 1'b1, 3'd5, 1'b1);
    set_v(42, 0, 1'b0, 1'b1, 3'd5, 1'b0);
    set_v(43, 0, 1'b0, 1'b1, 3'd5, 1'b0);
    set_v(44, 0, 1'b0, 1'b1, 3'd6, 1'b1);

    reset    = 1'b1;
    vsync    = 1'b1;
    auto_en  = 1'b0;
    step_btn = 1'b0;
    exp_fc   = 8'd0;

    // Reset held with vsync toggling: outputs stay at reset values.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vsync = c[0];
      @(posedge clk);
      #1;
      check($sformatf("rst%0d_idx", c), int'(color_index), 1);
      check($sformatf("rst%0d_adv", c), int'(advance), 0);
      check($sformatf("rst%0d_fcnt", c), int'(frame_cnt), 0);
      check($sformatf("rst%0d_auto", c), int'(auto_active), 0);
    end
    @(negedge clk);
    vsync = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i <= 10; i++) apply_vec(i);

    // Mid-frame reset with a press pending at index 5.
    press_btn();
    check("pre_rst_idx", int'(color_index), 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_idx", int'(color_index), 1);
    check("midrst_adv", int'(advance), 0);
    check("midrst_fcnt", int'(frame_cnt), 0);
    check("midrst_auto", int'(auto_active), 0);
    @(negedge clk);
    reset  = 1'b0;
    exp_fc = 8'd0;
    repeat (4) @(negedge clk);
    apply_vec(11);

    // Fresh start for the auto-mode run.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    exp_fc = 8'd0;
    repeat (2) @(negedge clk);
    for (int i = 12; i <= 44; i++) apply_vec(i);
    check("auto_run_fcnt", int'(frame_cnt), 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
